// File: rtl/capture_sync_ctrl.sv
// Capture channel sequencer: filter prescaler, edge-to-edge period timer and
// missing-tooth sync tracker feeding the angle-generation logic.
module capture_sync_ctrl #(
    parameter int TW = 16,
    parameter int CW = 8,
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic [PW-1:0] presc_val,
    input  logic [CW-1:0] tooth_total,
    input  logic          edge_in,
    output logic          filt_ena,
    output logic          out_ena,
    output logic [TW-1:0] period,
    output logic          period_valid,
    output logic [CW-1:0] tooth_num,
    output logic          synced,
    output logic          gap,
    output logic          sync_err
);

    typedef enum logic [2:0] {IDLE, FIRST, COLLECT, HUNT, SYNCED} state_t;

    state_t        state, state_n;
    logic [PW-1:0] pcnt;
    logic [TW-1:0] tmr, tmr_n, prev, prev_n, period_n, cur;
    logic [CW-1:0] tooth_n;
    logic          pv_n, synced_n, gap_n, err_n;
    logic          is_gap, expected, ovf;

    assign cur      = tmr + 1'b1;
    // Doubled prev kept at TW+1 bits so a large prev never wraps into a false gap.
    assign is_gap   = {1'b0, cur} > {prev, 1'b0};
    assign expected = (tooth_num == tooth_total - 1'b1);
    assign ovf      = (tmr == '1);
    // >= lets the counter recover at once if presc_val shrinks below it.
    assign filt_ena = ena && (pcnt >= presc_val);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt    <= '0;
            out_ena <= 1'b0;
        end else begin
            out_ena <= ena;
            if (!ena || pcnt >= presc_val) pcnt <= '0;
            else                           pcnt <= pcnt + 1'b1;
        end
    end

    always_comb begin
        state_n  = state;
        tmr_n    = tmr;
        prev_n   = prev;
        period_n = period;
        tooth_n  = tooth_num;
        synced_n = synced;
        pv_n     = 1'b0;
        gap_n    = 1'b0;
        err_n    = 1'b0;
        if (!ena) begin
            state_n  = IDLE;
            tmr_n    = '0;
            prev_n   = '0;
            period_n = '0;
            tooth_n  = '0;
            synced_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tmr_n   = '0;
                    state_n = FIRST;
                end
                FIRST: begin
                    tmr_n = '0;
                    if (edge_in) state_n = COLLECT;
                end
                default: begin
                    if (ovf) begin
                        // Timer overflow wins over a same-cycle edge; re-arm from scratch.
                        err_n    = 1'b1;
                        synced_n = 1'b0;
                        tooth_n  = '0;
                        prev_n   = '0;
                        tmr_n    = '0;
                        state_n  = FIRST;
                    end else begin
                        tmr_n = tmr + 1'b1;
                        if (edge_in) begin
                            tmr_n    = '0;
                            period_n = cur;
                            pv_n     = 1'b1;
                            case (state)
                                COLLECT: begin
                                    prev_n  = cur;
                                    state_n = HUNT;
                                end
                                HUNT: begin
                                    tooth_n = '0;
                                    if (is_gap) begin
                                        gap_n    = 1'b1;
                                        synced_n = 1'b1;
                                        state_n  = SYNCED;
                                    end else begin
                                        prev_n = cur;
                                    end
                                end
                                default: begin
                                    if (is_gap && expected) begin
                                        gap_n   = 1'b1;
                                        tooth_n = '0;
                                    end else if (!is_gap && !expected) begin
                                        tooth_n = tooth_num + 1'b1;
                                        prev_n  = cur;
                                    end else begin
                                        err_n    = 1'b1;
                                        synced_n = 1'b0;
                                        tooth_n  = '0;
                                        prev_n   = cur;
                                        state_n  = HUNT;
                                    end
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            tmr          <= '0;
            prev         <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            tooth_num    <= '0;
            synced       <= 1'b0;
            gap          <= 1'b0;
            sync_err     <= 1'b0;
        end else begin
            state        <= state_n;
            tmr          <= tmr_n;
            prev         <= prev_n;
            period       <= period_n;
            period_valid <= pv_n;
            tooth_num    <= tooth_n;
            synced       <= synced_n;
            gap          <= gap_n;
            sync_err     <= err_n;
        end
    end

endmodule

// File: tb/tb_capture_sync_ctrl.sv
// Directed bench for capture_sync_ctrl: prescaler, sync acquisition, tooth
// tracking, sync loss, timer overflow, ena drop and async reset.
module tb_capture_sync_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic [7:0]  presc_val = 8'd0;
    logic [7:0]  tooth_total = 8'd4;
    logic        edge_in = 1'b0;
    logic        filt_ena, out_ena, period_valid, synced, gap, sync_err;
    logic [15:0] period;
    logic [7:0]  tooth_num;

    int errors = 0;
    int checks = 0;

    capture_sync_ctrl #(.TW(16), .CW(8), .PW(8)) dut (
        .clk(clk), .rst(rst), .ena(ena), .presc_val(presc_val),
        .tooth_total(tooth_total), .edge_in(edge_in), .filt_ena(filt_ena),
        .out_ena(out_ena), .period(period), .period_valid(period_valid),
        .tooth_num(tooth_num), .synced(synced), .gap(gap), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge just after the previous edge; the next edge lands n clocks later.
    task automatic send_edge(input int n);
        repeat (n - 1) @(negedge clk);
        edge_in = 1'b1;
        @(negedge clk);
        edge_in = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_filt"}, 32'(filt_ena), 0);
        chk({tag, "_oena"}, 32'(out_ena), 0);
        chk({tag, "_per"}, 32'(period), 0);
        chk({tag, "_pv"}, 32'(period_valid), 0);
        chk({tag, "_tooth"}, 32'(tooth_num), 0);
        chk({tag, "_sync"}, 32'(synced), 0);
        chk({tag, "_gap"}, 32'(gap), 0);
        chk({tag, "_err"}, 32'(sync_err), 0);
    endtask

    task automatic chk_edge(input string tag, input int per, input int tooth,
                            input int syn, input int g, input int err);
        chk({tag, "_pv"}, 32'(period_valid), 1);
        chk({tag, "_per"}, 32'(period), per);
        chk({tag, "_tooth"}, 32'(tooth_num), tooth);
        chk({tag, "_sync"}, 32'(synced), syn);
        chk({tag, "_gap"}, 32'(gap), g);
        chk({tag, "_err"}, 32'(sync_err), err);
    endtask

    initial begin
        int cnt;
        int pat[4] = '{10, 10, 10, 30};

        // reset state
        repeat (2) @(negedge clk);
        chk_all_zero("rst");
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("idle");

        // 1: prescaler and out_ena
        presc_val = 8'd3;
        ena = 1'b1;
        #1 chk("oena_before", 32'(out_ena), 0);
        @(negedge clk);
        chk("oena_after", 32'(out_ena), 1);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (filt_ena) cnt++;
            @(negedge clk);
        end
        chk("filt_1of4", 32'(cnt), 4);
        presc_val = 8'd0;
        #1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (filt_ena) cnt++;
            @(negedge clk);
        end
        chk("filt_always", 32'(cnt), 8);
        presc_val = 8'd3;

        // 2: acquisition
        send_edge(5);
        chk("first_pv", 32'(period_valid), 0);
        chk("first_sync", 32'(synced), 0);
        send_edge(10);
        chk_edge("collect", 10, 0, 0, 0, 0);
        send_edge(10);
        chk_edge("hunt10", 10, 0, 0, 0, 0);
        send_edge(30);
        chk_edge("hunt_gap", 30, 0, 1, 1, 0);
        @(negedge clk);
        chk("gap_onecycle", 32'(gap), 0);
        chk("pv_onecycle", 32'(period_valid), 0);

        // 3: three revolutions of tooth tracking (one clock already consumed above)
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 4; k++) begin
                send_edge((r == 0 && k == 0) ? pat[k] - 1 : pat[k]);
                chk_edge($sformatf("rev%0d_t%0d", r, k), pat[k], (k + 1) % 4, 1,
                         (k == 3) ? 1 : 0, 0);
            end

        // 4: early gap loses sync, then resync
        send_edge(10);
        chk_edge("pre_bad", 10, 1, 1, 0, 0);
        send_edge(30);
        chk_edge("bad_gap", 30, 0, 0, 0, 1);
        send_edge(10);
        chk_edge("rehunt1", 10, 0, 0, 0, 0);
        send_edge(10);
        chk_edge("rehunt2", 10, 0, 0, 0, 0);
        send_edge(30);
        chk_edge("resync", 30, 0, 1, 1, 0);

        // 5: timer overflow with a coincident edge
        repeat (65535) @(negedge clk);
        chk("pre_ovf_sync", 32'(synced), 1);
        chk("pre_ovf_err", 32'(sync_err), 0);
        edge_in = 1'b1;
        @(negedge clk);
        edge_in = 1'b0;
        chk("ovf_err", 32'(sync_err), 1);
        chk("ovf_sync", 32'(synced), 0);
        chk("ovf_pv", 32'(period_valid), 0);
        chk("ovf_tooth", 32'(tooth_num), 0);
        chk("ovf_per", 32'(period), 30);
        send_edge(10);
        chk("rearm_pv", 32'(period_valid), 0);
        chk("rearm_err", 32'(sync_err), 0);
        chk("rearm_per", 32'(period), 30);
        send_edge(10);
        chk_edge("post_ovf", 10, 0, 0, 0, 0);
        send_edge(30);
        chk_edge("post_ovf_sync", 30, 0, 1, 1, 0);

        // 6a: ena drop while synced
        send_edge(10);
        chk_edge("pre_drop", 10, 1, 1, 0, 0);
        ena = 1'b0;
        @(negedge clk);
        chk_all_zero("ena_drop");
        ena = 1'b1;
        send_edge(5);
        chk("reen_first_pv", 32'(period_valid), 0);
        send_edge(10);
        chk_edge("reen_collect", 10, 0, 0, 0, 0);
        send_edge(10);
        chk_edge("reen_hunt", 10, 0, 0, 0, 0);
        send_edge(30);
        chk_edge("reen_sync", 30, 0, 1, 1, 0);

        // 6b: async reset mid-revolution
        send_edge(10);
        chk_edge("pre_rst", 10, 1, 1, 0, 0);
        send_edge(10);
        rst = 1'b1;
        #1 chk_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        send_edge(5);
        chk("rst_first_pv", 32'(period_valid), 0);
        send_edge(10);
        chk_edge("rst_collect", 10, 0, 0, 0, 0);
        send_edge(10);
        chk_edge("rst_hunt", 10, 0, 0, 0, 0);
        send_edge(30);
        chk_edge("rst_sync", 30, 0, 1, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
